// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage RV32I core: PC register, next-PC select and the
// IF/ID pipeline register, plus saturating stall/flush counters for debug.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic [CNT_WIDTH-1:0]  StallCount,
  output logic [CNT_WIDTH-1:0]  FlushCount
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  if_id_t                if_id_q, if_id_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  assign pc_plus4_f = pc_q + PC_STEP;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    pc_d        = pc_q;
    if_id_d     = if_id_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // A taken branch in E is older than any load-use stall, so it wins over StallF.
    if (PCSrcE) begin
      pc_d = PCTargetE;
    end else if (!StallF) begin
      pc_d = pc_plus4_f;
    end

    if (FlushD) begin
      if_id_d = BUBBLE;
    end else if (!StallD) begin
      if_id_d = '{instr: InstrF, pc: pc_q, pc_plus4: pc_plus4_f, valid: 1'b1};
    end

    // A cycle that is both stalled and flushed is counted as a flush only.
    if (FlushD) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (StallD) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pc_q        <= RESET_PC;
      if_id_q     <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCF        = pc_q;
  assign InstrD     = if_id_q.instr;
  assign PCD        = if_id_q.pc;
  assign PCPlus4D   = if_id_q.pc_plus4;
  assign ValidD     = if_id_q.valid;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, a cycle-level reference model of the
// fetch/decode slot, a per-cycle compare process and hand-computed anchor checks.
module tb_fetch_stage;

  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_pass  = 0;
  int n_total = 0;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // Instruction memory: every word is tagged with its own address.
  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  assign InstrF = instr_at(PCF);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: what the fetch address and decode slot must hold after each edge.
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
  logic        m_valid;
  int          m_stalls, m_flushes;
  bit          m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
      m_stalls = 0; m_flushes = 0; m_ok = 1;
    end else if (m_ok) begin
      if (FlushD)      m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
      else if (StallD) m_stalls  = (m_stalls  < CNT_MAX) ? m_stalls  + 1 : CNT_MAX;
      if (FlushD) begin
        m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
      end else if (!StallD) begin
        m_instr = instr_at(m_pc); m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1;
      end
      if (PCSrcE)       m_pc = PCTargetE;
      else if (!StallF) m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("PCF",        PCF,               m_pc);
      check("InstrD",     InstrD,            m_instr);
      check("PCD",        PCD,               m_pcd);
      check("PCPlus4D",   PCPlus4D,          m_pcp4);
      check("ValidD",     32'(ValidD),       32'(m_valid));
      check("StallCount", 32'(StallCount),   32'(m_stalls));
      check("FlushCount", 32'(FlushCount),   32'(m_flushes));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fd,
                       input logic br, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = br; PCTargetE = tgt;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    cyc(1);
    check("rst_pcf",    PCF, 32'h0);
    check("rst_instrd", InstrD, NOP);
    check("rst_validd", 32'(ValidD), 32'h0);

    // Free run from reset
    rst = 1'b0;
    cyc(1);
    check("first_validd", 32'(ValidD), 32'h1);
    cyc(3);
    check("run_pcf",      PCF,      32'h10);
    check("run_pcd",      PCD,      32'hC);
    check("run_instrd",   InstrD,   32'hC0DE_000C);
    check("run_pcplus4d", PCPlus4D, 32'h10);

    // Full stall at PCF=0x10
    drive(1, 1, 0, 0, 32'h0);
    cyc(3);
    check("stall_pcf",   PCF, 32'h10);
    check("stall_pcd",   PCD, 32'hC);
    check("stall_count", 32'(StallCount), 32'd3);
    drive(0, 0, 0, 0, 32'h0);
    cyc(1);
    check("resume_pcf", PCF, 32'h14);

    // Taken branch from PCF=0x20
    cyc(3);
    check("pre_branch_pcf", PCF, 32'h20);
    drive(0, 0, 1, 1, 32'h200);
    cyc(1);
    check("br_pcf",    PCF, 32'h200);
    check("br_instrd", InstrD, NOP);
    check("br_validd", 32'(ValidD), 32'h0);
    check("br_flushc", 32'(FlushCount), 32'd1);
    drive(0, 0, 0, 0, 32'h0);
    cyc(1);
    check("br_tgt_pcd", PCD, 32'h200);

    // Redirect together with both stalls and a flush
    drive(1, 1, 1, 1, 32'h300);
    cyc(1);
    check("mix_pcf",    PCF, 32'h300);
    check("mix_validd", 32'(ValidD), 32'h0);
    check("mix_flushc", 32'(FlushCount), 32'd2);
    check("mix_stallc", 32'(StallCount), 32'd3);
    drive(0, 0, 0, 0, 32'h0);
    cyc(1);

    // PC wrap at the top of the address space
    drive(0, 0, 1, 1, 32'hFFFF_FFFC);
    cyc(1);
    drive(0, 0, 0, 0, 32'h0);
    cyc(1);
    check("wrap_pcf",      PCF,      32'h0);
    check("wrap_pcd",      PCD,      32'hFFFF_FFFC);
    check("wrap_pcplus4d", PCPlus4D, 32'h0);

    // Unaligned target is loaded as-is
    drive(0, 0, 0, 1, 32'h103);
    cyc(1);
    drive(0, 0, 0, 0, 32'h0);
    cyc(1);
    check("unalign_pcf", PCF, 32'h107);

    // Independent stalls
    drive(1, 0, 0, 0, 32'h0);
    cyc(1);
    check("stallf_only_pcf", PCF, 32'h107);
    check("stallf_only_pcd", PCD, 32'h107);
    drive(0, 1, 0, 0, 32'h0);
    cyc(1);
    check("stalld_only_pcf", PCF, 32'h10B);
    check("stalld_only_pcd", PCD, 32'h107);
    drive(0, 0, 1, 0, 32'h0);
    cyc(1);

    // Saturation of both counters (stall count is 4, flush count 4 here)
    drive(1, 1, 0, 0, 32'h0);
    cyc(16);
    check("stall_sat", 32'(StallCount), 32'hF);
    cyc(2);
    check("stall_sat_hold", 32'(StallCount), 32'hF);
    drive(0, 0, 1, 0, 32'h0);
    cyc(13);
    check("flush_sat", 32'(FlushCount), 32'hF);

    // Reset during a stalled redirect
    drive(1, 1, 0, 1, 32'h500);
    rst = 1'b1;
    cyc(1);
    check("rst2_pcf",    PCF, 32'h0);
    check("rst2_instrd", InstrD, NOP);
    check("rst2_pcd",    PCD, 32'h0);
    check("rst2_stallc", 32'(StallCount), 32'h0);
    check("rst2_flushc", 32'(FlushCount), 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    cyc(1);
    check("post_rst_pcf",    PCF, 32'h4);
    check("post_rst_validd", 32'(ValidD), 32'h1);
    check("post_rst_instrd", InstrD, 32'hC0DE_0000);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
